// File: rtl/sfp_pkg.sv
// Shared types and widths for the SFP softmax-sum exchange blocks.
package sfp_pkg;

  localparam int BW       = 8;
  localparam int BW_PSUM  = 2 * BW + 4;
  localparam int SUM_W    = BW_PSUM + 4;
  localparam int RX_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE
  } rx_state_t;

endpackage

// File: rtl/sum_rx_buf.sv
// 16-entry circular sum buffer with occupancy count and a registered head word.
module sum_rx_buf
  import sfp_pkg::*;
#(
  parameter int W = SUM_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_vld,
  output logic [4:0]   o_occ
);

  logic [W-1:0] r_mem [RX_DEPTH];
  logic [3:0]   r_rd_ptr;
  logic [3:0]   r_wr_ptr;
  logic [4:0]   r_occ;
  logic [W-1:0] r_head;

  logic         w_pop;
  logic [3:0]   w_rd_nxt;
  logic [4:0]   w_occ_nxt;
  logic [W-1:0] w_head_nxt;

  assign w_pop     = i_pop && (r_occ != 5'd0);
  assign w_rd_nxt  = r_rd_ptr + {3'b0, w_pop};
  assign w_occ_nxt = r_occ + {4'b0, i_wr} - {4'b0, w_pop};

  // Head follows the next read pointer; a word written into that slot this
  // cycle is bypassed so it is visible the cycle after the write.
  always_comb begin
    w_head_nxt = r_head;
    if (w_occ_nxt != 5'd0) begin
      if (i_wr && (r_wr_ptr == w_rd_nxt)) w_head_nxt = i_wr_data;
      else                                w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= 4'd0;
      r_wr_ptr <= 4'd0;
      r_occ    <= 5'd0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      if (i_wr) r_wr_ptr <= r_wr_ptr + 4'd1;
      r_occ    <= w_occ_nxt;
      r_head   <= w_head_nxt;
    end
  end

  assign o_head = r_head;
  assign o_vld  = (r_occ != 5'd0);
  assign o_occ  = r_occ;

endmodule

// File: rtl/sfp_sum_rx.sv
// Fetches peer row sums into a local buffer and presents them one per div.
// Optional SUM_RX_ZERO_ON_EMPTY_EN: sum_in reads 0 whenever the buffer is empty.
module sfp_sum_rx
  import sfp_pkg::*;
#(
  parameter int bw      = 8,
  parameter int bw_psum = 2 * bw + 4,
  parameter int depth   = RX_DEPTH,
  parameter int rd_lat  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         n_rows,
  input  logic               peer_rdy,
  output logic               peer_rd,
  input  logic [bw_psum+3:0] peer_sum,
  input  logic               div,
  output logic [bw_psum+3:0] sum_in,
  output logic               sum_vld,
  output logic               busy,
  output logic               done,
  output logic               err,
  output rx_state_t          o_dbg_state
);

  localparam int SW = bw_psum + 4;

  rx_state_t         r_state;
  logic [4:0]        r_n_rows;
  logic [4:0]        r_issued;
  logic [rd_lat-1:0] r_vld_sr;
  logic              r_err;

  logic [2:0]        w_in_flight;
  logic              w_space;
  logic              w_issue;
  logic              w_land;
  logic [SW-1:0]     w_head;
  logic              w_vld;
  logic [4:0]        w_occ;

  always_comb begin
    w_in_flight = 3'd0;
    for (int i = 0; i < rd_lat; i++) w_in_flight = w_in_flight + {2'b0, r_vld_sr[i]};
  end

  // Space is reserved at issue time so a landing word can never overflow.
  assign w_space = ({1'b0, w_occ} + {3'b0, w_in_flight}) < 6'(depth);
  assign w_issue = reset_n && (r_state == FETCH) && peer_rdy &&
                   (r_issued < r_n_rows) && w_space;
  assign w_land  = r_vld_sr[rd_lat-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= w_issue;
      for (int i = 1; i < rd_lat; i++) r_vld_sr[i] <= r_vld_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_n_rows <= 5'd0;
      r_issued <= 5'd0;
      r_err    <= 1'b0;
    end else begin
      if (div && !w_vld) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_issued <= 5'd0;
            if (n_rows > 5'(depth)) begin
              r_n_rows <= 5'(depth);
              r_err    <= 1'b1;
              r_state  <= FETCH;
            end else begin
              r_n_rows <= n_rows;
              r_state  <= (n_rows == 5'd0) ? DONE : FETCH;
            end
          end
        end
        FETCH: begin
          if (w_issue) begin
            r_issued <= r_issued + 5'd1;
            if (r_issued + 5'd1 == r_n_rows) r_state <= WAIT;
          end
        end
        WAIT:    if (w_in_flight == 3'd0) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  sum_rx_buf #(.W(SW)) u_buf (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_wr      (w_land),
    .i_wr_data (peer_sum),
    .i_pop     (div),
    .o_head    (w_head),
    .o_vld     (w_vld),
    .o_occ     (w_occ)
  );

`ifdef SUM_RX_ZERO_ON_EMPTY_EN
  assign sum_in = w_vld ? w_head : '0;
`else
  assign sum_in = w_head;
`endif

  assign peer_rd     = w_issue;
  assign sum_vld     = w_vld;
  assign busy        = (r_state == FETCH) || (r_state == WAIT);
  assign done        = (r_state == DONE);
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule
